// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage controller.
// State encoding, default address base, timeout limit and poison value.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int unsigned TIMEOUT_DEF   = 255;
    localparam logic [31:0] POISON        = 32'hDEADBEEF;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Word-addressed data memory request/acknowledge port.
// master drives requests, slave is the memory.
interface mem_stage_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/Reg.sv
// Generic enabled register with asynchronous active-low clear.
// Holds its value whenever en is low.
module Reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the front end while a load/store handshakes.
// Define MEM_STAGE_TIMEOUT_EN to add an ack timeout with sticky mem_err.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      WB_en_in,
    input  logic                      MEM_R_en_in,
    input  logic                      MEM_W_en_in,
    input  logic [31:0]               ALU_result_in,
    input  logic [31:0]               Val_Rm_in,
    input  logic [3:0]                Dest_in,
    output logic                      WB_en,
    output logic                      MEM_R_en,
    output logic [31:0]               ALU_result,
    output logic [31:0]               Mem_read_value,
    output logic [3:0]                Dest,
    output logic                      freeze,
    mem_stage_ctrl_if.master          mem,
    output logic                      mem_err
);

    state_e      state_q, state_d;
    logic        mem_op;
    logic        cap_en;
    logic [31:0] cap_d;
    logic [31:0] offset;
    logic [1:0]  unused_lsb;
    logic        tmo;

    assign mem_op     = MEM_R_en_in | MEM_W_en_in;
    assign offset     = ALU_result_in - BASE_ADDR;
    assign unused_lsb = offset[1:0];

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = '0;
        tmo   = 1'b0;
        err_d = err_q;
        if (state_q == REQ && !mem.mem_ack) begin
            if (cnt_q == TMO_LAST) begin
                tmo   = 1'b1;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
    assign cap_d   = tmo ? POISON : mem.mem_rdata;
`else
    assign tmo     = 1'b0;
    assign mem_err = 1'b0;
    assign cap_d   = mem.mem_rdata;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_op) state_d = REQ;
            REQ:     if (mem.mem_ack || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Loads capture data; a timeout poisons the register instead.
    assign cap_en = (state_q == REQ) &
                    ((mem.mem_ack & MEM_R_en_in) | tmo);

    Reg #(.WIDTH(32)) u_rd_reg (
        .clk (clk),
        .rst (rst),
        .en  (cap_en),
        .d   (cap_d),
        .q   (Mem_read_value)
    );

    always_comb begin
        freeze = rst & (((state_q == IDLE) & mem_op) |
                        (state_q == REQ));
        WB_en      = WB_en_in & ~freeze;
        MEM_R_en   = MEM_R_en_in & ~freeze;
        ALU_result = ALU_result_in;
        Dest       = Dest_in;
    end

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = (state_q == REQ) & MEM_W_en_in;
    assign mem.mem_addr  = offset[31:2];
    assign mem.mem_wdata = Val_Rm_in;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level model.
// Timeout scenario runs only when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in, MEM_R_en_in, MEM_W_en_in;
    logic [31:0] ALU_result_in, Val_Rm_in;
    logic [3:0]  Dest_in;
    logic        WB_en, MEM_R_en, freeze, mem_err;
    logic [31:0] ALU_result, Mem_read_value;
    logic [3:0]  Dest;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic req_prev = 1'b0;
    logic [31:0] model_rd = 32'h0;
    logic        exp_err = 1'b0;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl #(
        .BASE_ADDR      (32'd1024),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_en_in       (WB_en_in),
        .MEM_R_en_in    (MEM_R_en_in),
        .MEM_W_en_in    (MEM_W_en_in),
        .ALU_result_in  (ALU_result_in),
        .Val_Rm_in      (Val_Rm_in),
        .Dest_in        (Dest_in),
        .WB_en          (WB_en),
        .MEM_R_en       (MEM_R_en),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Dest           (Dest),
        .freeze         (freeze),
        .mem            (mif.master),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mif.mem_req && !req_prev) pulses++;
        req_prev = mif.mem_req;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] word_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return off[31:2];
    endfunction

    task automatic set_in(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] val,
                          input logic [3:0] d);
        WB_en_in = wb; MEM_R_en_in = r; MEM_W_en_in = w;
        ALU_result_in = alu; Val_Rm_in = val; Dest_in = d;
    endtask

    // One instruction through the stage; the memory acks after `waits`
    // idle REQ cycles. `stray` raises ack outside REQ to show it is ignored.
    task automatic run_instr(input logic wb, input logic r, input logic w,
                             input logic [31:0] alu, input logic [31:0] val,
                             input logic [3:0] d, input int waits,
                             input logic [31:0] rdata, input logic stray);
        int fz;
        set_in(wb, r, w, alu, val, d);
        mif.mem_ack = stray;
        mif.mem_rdata = $urandom;
        @(negedge clk);
        if (!(r || w)) begin
            check("pass_freeze", freeze, 0);
            check("pass_req", mif.mem_req, 0);
            check("pass_alu", ALU_result, alu);
            check("pass_wb", WB_en, wb);
            check("pass_dest", Dest, d);
            check("pass_rd", Mem_read_value, model_rd);
            step();
            return;
        end
        fz = int'(freeze);
        check("idle_freeze", freeze, 1);
        check("idle_req", mif.mem_req, 0);
        check("idle_bubble", WB_en, 0);
        step();
        for (int k = 0; k <= waits; k++) begin
            mif.mem_ack = (k == waits);
            mif.mem_rdata = (k == waits) ? rdata : $urandom;
            @(negedge clk);
            fz += int'(freeze);
            check("req_req", mif.mem_req, 1);
            check("req_we", mif.mem_we, w);
            check("req_addr", mif.mem_addr, word_addr(alu));
            check("req_wdata", mif.mem_wdata, val);
            check("req_bubble", MEM_R_en, 0);
            step();
        end
        exp_pulses++;
        if (r) model_rd = rdata;
        mif.mem_ack = stray;
        mif.mem_rdata = $urandom;
        @(negedge clk);
        check("done_freeze", freeze, 0);
        check("done_req", mif.mem_req, 0);
        check("done_rd", Mem_read_value, model_rd);
        check("done_wb", WB_en, wb);
        check("done_mr", MEM_R_en, r);
        check("done_alu", ALU_result, alu);
        check("freeze_len", fz, waits + 2);
        step();
    endtask

    initial begin
        logic r;
        logic [31:0] a;
        rst = 1'b0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 32'h0;
        set_in(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'h3);
        #2;
        check("rst_req", mif.mem_req, 0);
        check("rst_freeze", freeze, 0);
        check("rst_rd", Mem_read_value, 0);
        check("rst_err", mem_err, 0);
        check("rst_alu", ALU_result, 32'h55);
        @(negedge clk);
        rst = 1'b1;
        step();

        run_instr(1, 0, 0, 32'h55, 32'h0, 4'h1, 0, 0, 0);
        run_instr(1, 1, 0, 32'd1032, 32'h0, 4'h2, 2,
                  32'h12345678, 0);
        run_instr(0, 0, 1, 32'd1028, 32'hCAFEF00D, 4'h0, 0, 0, 1);
        check("str_keeps_rd", Mem_read_value, 32'h12345678);
        run_instr(1, 1, 0, 32'd2048, 32'h0, 4'h4, 0, 32'hA5A5A5A5, 0);
        run_instr(1, 1, 0, 32'd2052, 32'h0, 4'h5, 1, 32'h5A5A5A5A, 0);

        // Reset during the second REQ cycle abandons the access.
        set_in(1, 1, 0, 32'd1100, 32'h0, 4'h6);
        mif.mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        exp_pulses++;
        model_rd = 32'h0;
        check("abort_req", mif.mem_req, 0);
        check("abort_rd", Mem_read_value, 0);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hBADBAD00;
        set_in(1, 0, 0, 32'h77, 32'h0, 4'h7);
        @(negedge clk);
        rst = 1'b1;
        step();
        #1;
        check("late_ack_req", mif.mem_req, 0);
        check("late_ack_rd", Mem_read_value, 0);
        mif.mem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 32'd1024 + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0)
                run_instr(1'($urandom), 0, 0, $urandom, $urandom,
                          4'($urandom), 0, 0, 1'($urandom));
            else
                run_instr(r, r, !r, a, $urandom, 4'($urandom),
                          $urandom_range(0, 3), $urandom, 1'($urandom));
        end

`ifdef MEM_STAGE_TIMEOUT_EN
        set_in(1, 1, 0, 32'd1040, 32'h0, 4'h8);
        mif.mem_ack = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("tmo_req", mif.mem_req, 1);
            step();
        end
        exp_pulses++;
        exp_err = 1'b1;
        model_rd = 32'hDEADBEEF;
        @(negedge clk);
        check("tmo_done_freeze", freeze, 0);
        check("tmo_poison", Mem_read_value, 32'hDEADBEEF);
        check("tmo_err", mem_err, 1);
        step();
        run_instr(1, 0, 0, 32'h12, 32'h0, 4'h9, 0, 0, 0);
`endif

        @(negedge clk);
        check("err_flag", mem_err, exp_err);
        check("req_pulses", pulses, exp_pulses);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 1024, the byte address subtracted from ALU_result to form the memory offset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles to wait for mem_ack (used only when the timeout feature is compiled in).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have EXE-side inputs: WB_en_in 1, MEM_R_en_in 1, MEM_W_en_in 1, ALU_result_in 32 (byte address or ALU value), Val_Rm_in 32 (store data), Dest_in 4.
REQ-006 The block SHALL have MEM/WB-register-side outputs: WB_en 1, MEM_R_en 1, ALU_result 32, Mem_read_value 32, Dest 4.
REQ-007 The block SHALL have output freeze, 1: stall request to the PC, IF/ID and ID/EXE registers.
REQ-008 The block SHALL have a memory port: mem_req out 1, mem_we out 1, mem_addr out 30 (word address), mem_wdata out 32, mem_rdata in 32, mem_ack in 1.
REQ-009 The block SHALL have output mem_err, 1: sticky timeout flag.

Function
REQ-010 The FSM SHALL have exactly three states, IDLE, REQ and DONE; reset state IDLE.
REQ-011 IDLE with neither MEM_R_en_in nor MEM_W_en_in: outputs SHALL be a pure pass-through of the *_in values, freeze=0, mem_req=0, zero added latency.
REQ-012 IDLE with MEM_R_en_in or MEM_W_en_in: freeze=1 combinationally in that cycle; next state REQ.
REQ-013 REQ: mem_req=1; mem_we=MEM_W_en_in; mem_addr=(ALU_result_in-BASE_ADDR)[31:2]; mem_wdata=Val_Rm_in; all held stable until mem_ack is sampled high.
REQ-014 REQ with mem_ack=1: mem_rdata SHALL be captured into the read-data register (reads only; writes leave it unchanged) and next state DONE; mem_req drops the following cycle.
REQ-015 DONE: freeze=0, mem_req=0, outputs pass through with Mem_read_value = captured register; next state IDLE unconditionally.
REQ-016 While freeze=1, WB_en and MEM_R_en outputs SHALL be forced 0, so the MEM/WB register captures a bubble.
REQ-017 Minimum access latency: 3 cycles (IDLE detect, REQ with same-cycle ack, DONE); each extra cycle without mem_ack adds one.
REQ-018 mem_ack asserted outside REQ SHALL be ignored.
REQ-019 Back-to-back accesses: the instruction arriving in the cycle after DONE SHALL start a fresh IDLE->REQ sequence; no access is ever issued twice.
REQ-020 Byte addresses are word-aligned; ALU_result_in[1:0] SHALL be ignored.

Reset
REQ-021 rst low SHALL immediately set state IDLE, mem_req=0, read-data register 0x00000000, mem_err=0, timeout counter 0.
REQ-022 Reset in REQ SHALL abandon the access with no further mem_req; the in-flight ack is ignored.
REQ-023 In reset, freeze and data-path outputs SHALL follow REQ-011 (combinational pass-through).

Configuration
REQ-024 Macro MEM_STAGE_TIMEOUT_EN defined: a counter SHALL count cycles in REQ; at TIMEOUT_CYCLES without ack the FSM goes to DONE, Mem_read_value=0xDEADBEEF, mem_err set until reset.
REQ-025 MEM_STAGE_TIMEOUT_EN undefined: no counter exists, REQ waits indefinitely, mem_err tied 0.

Structure
REQ-026 Shared package mem_stage_pkg SHALL hold the state enum, the default BASE_ADDR, TIMEOUT_CYCLES and the 0xDEADBEEF poison constant.
REQ-027 The read-data register SHALL be an instance of the team's generic Reg module (WIDTH 32, enable = ack in REQ); no other sub-modules.

Verification
REQ-028 ADD (no mem op), ALU_result_in=0x55 -> same cycle ALU_result=0x55, freeze=0, mem_req never asserted.
REQ-029 LDR, ALU_result_in=1032, ack after 2 waits, mem_rdata=0x12345678 -> mem_addr=2, freeze high for 4 cycles, DONE shows Mem_read_value=0x12345678, WB_en=1.
REQ-030 STR, ALU_result_in=1028, Val_Rm_in=0xCAFEF00D, same-cycle ack -> mem_we=1, mem_addr=1, mem_wdata=0xCAFEF00D, freeze for 2 cycles, read register unchanged.
REQ-031 LDR then LDR back-to-back -> exactly two mem_req pulses, two DONE cycles, no duplicate access.
REQ-032 rst low in the 2nd REQ cycle -> mem_req=0 immediately, state IDLE; a late mem_ack produces no capture.
REQ-033 MEM_STAGE_TIMEOUT_EN with TIMEOUT_CYCLES=8, ack never given -> DONE after 8 REQ cycles, Mem_read_value=0xDEADBEEF, mem_err=1 until reset.
